// File: rtl/rotenc_pkg.sv
//------------------------------------------------------------------------------
// Module   : rotenc_pkg
// Brief    : Shared types and constants for the rotary encoder controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rotenc_pkg;

    typedef enum logic [2:0] {
        REST = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6
    } rotenc_state_t;

    // Idle pin levels: encoder contacts pulled high, switch released
    localparam logic       c_rst_a  = 1'b1;
    localparam logic       c_rst_b  = 1'b1;
    localparam logic       c_rst_sw = 1'b0;
    localparam logic [1:0] c_detent = 2'b11;

endpackage

`default_nettype wire

// File: rtl/rotenc_db_filt.sv
//------------------------------------------------------------------------------
// Module   : rotenc_db_filt
// Brief    : 2-flop synchronizer plus tick-sampled debounce filter for one pin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rotenc_db_filt #(
    parameter int   DB_SAMPLES = 3,
    parameter logic RST_LVL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic pin,
    output logic level
);

    localparam logic [2:0] c_last = 3'(DB_SAMPLES - 1);

    logic [1:0] r_sync;
    logic       r_level;
    logic [2:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= {2{RST_LVL}};
            r_level <= RST_LVL;
            r_cnt   <= 3'd0;
        end else begin
            r_sync <= {r_sync[0], pin};
            if (tick) begin
                if (r_sync[1] != r_level) begin
                    // Toggle on the DB_SAMPLES-th consecutive differing sample
                    if (r_cnt == c_last) begin
                        r_level <= ~r_level;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end else begin
                    r_cnt <= 3'd0;
                end
            end
        end
    end

    assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/rotenc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rotenc_ctrl
// Brief    : Pmod rotary encoder controller: debounce, quadrature decode,
//            signed position count, press detect and sticky event flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rotenc_ctrl
    import rotenc_pkg::*;
#(
    parameter int TICK_N     = 19,
    parameter int DB_SAMPLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_sw,
    input  logic             clr,
    input  logic             ack,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step_pulse,
    output logic             btn_level,
    output logic             btn_press,
    output logic             evt
);

    logic [TICK_N-1:0] r_tick_cnt;
    logic              w_tick;
    logic              w_a_db;
    logic              w_b_db;
    logic              w_sw_db;
    logic [1:0]        w_ab;
    rotenc_state_t     r_state;
    rotenc_state_t     w_state_nxt;
    logic              w_step_cw;
    logic              w_step_ccw;
    logic [CNT_W-1:0]  r_count;
    logic              r_dir;
    logic              r_step_pulse;
    logic              r_sw_prev;
    logic              r_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_tick_cnt <= '0;
        else       r_tick_cnt <= r_tick_cnt + TICK_N'(1);
    end

    assign w_tick = (r_tick_cnt == '0);

    rotenc_db_filt #(.DB_SAMPLES(DB_SAMPLES), .RST_LVL(c_rst_a)) u_filt_a (
        .clk(clk), .reset(reset), .tick(w_tick), .pin(enc_a), .level(w_a_db)
    );

    rotenc_db_filt #(.DB_SAMPLES(DB_SAMPLES), .RST_LVL(c_rst_b)) u_filt_b (
        .clk(clk), .reset(reset), .tick(w_tick), .pin(enc_b), .level(w_b_db)
    );

    rotenc_db_filt #(.DB_SAMPLES(DB_SAMPLES), .RST_LVL(c_rst_sw)) u_filt_sw (
        .clk(clk), .reset(reset), .tick(w_tick), .pin(enc_sw), .level(w_sw_db)
    );

    assign w_ab = {w_a_db, w_b_db};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= REST;
        else       r_state <= w_state_nxt;
    end

    // A step is only credited when a full detent-to-detent sequence completes
    always_comb begin
        w_state_nxt = r_state;
        w_step_cw   = 1'b0;
        w_step_ccw  = 1'b0;
        case (r_state)
            REST: begin
                if (w_ab == 2'b01)      w_state_nxt = CW1;
                else if (w_ab == 2'b10) w_state_nxt = CCW1;
            end
            CW1: begin
                if (w_ab == 2'b00)         w_state_nxt = CW2;
                else if (w_ab == c_detent) w_state_nxt = REST;
            end
            CW2: begin
                if (w_ab == 2'b10)         w_state_nxt = CW3;
                else if (w_ab == 2'b01)    w_state_nxt = CW1;
                else if (w_ab == c_detent) w_state_nxt = REST;
            end
            CW3: begin
                if (w_ab == c_detent) begin
                    w_state_nxt = REST;
                    w_step_cw   = 1'b1;
                end else if (w_ab == 2'b00) begin
                    w_state_nxt = CW2;
                end
            end
            CCW1: begin
                if (w_ab == 2'b00)         w_state_nxt = CCW2;
                else if (w_ab == c_detent) w_state_nxt = REST;
            end
            CCW2: begin
                if (w_ab == 2'b01)         w_state_nxt = CCW3;
                else if (w_ab == 2'b10)    w_state_nxt = CCW1;
                else if (w_ab == c_detent) w_state_nxt = REST;
            end
            CCW3: begin
                if (w_ab == c_detent) begin
                    w_state_nxt = REST;
                    w_step_ccw  = 1'b1;
                end else if (w_ab == 2'b00) begin
                    w_state_nxt = CCW2;
                end
            end
            default: w_state_nxt = REST;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_dir        <= 1'b0;
            r_step_pulse <= 1'b0;
            r_sw_prev    <= c_rst_sw;
            r_evt        <= 1'b0;
        end else begin
            r_step_pulse <= w_step_cw | w_step_ccw;
            r_sw_prev    <= w_sw_db;
            // clr has priority over a coincident step
            if (clr)             r_count <= '0;
            else if (w_step_cw)  r_count <= r_count + CNT_W'(1);
            else if (w_step_ccw) r_count <= r_count - CNT_W'(1);
            if (w_step_cw | w_step_ccw) r_dir <= w_step_cw;
            if (r_step_pulse | btn_press) r_evt <= 1'b1;
            else if (ack)                 r_evt <= 1'b0;
        end
    end

    assign count      = r_count;
    assign dir        = r_dir;
    assign step_pulse = r_step_pulse;
    assign btn_level  = w_sw_db;
    assign btn_press  = w_sw_db & ~r_sw_prev;
    assign evt        = r_evt;

endmodule

`default_nettype wire

// File: tb/tb_rotenc_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rotenc_ctrl
// Brief    : Directed self-checking bench for rotenc_ctrl with step scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rotenc_ctrl;
    import rotenc_pkg::*;

    localparam int TICK_N     = 4;
    localparam int DB_SAMPLES = 3;
    localparam int CNT_W      = 8;
    localparam int HOLD       = 80;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enc_a = 1'b1;
    logic             enc_b = 1'b1;
    logic             enc_sw = 1'b0;
    logic             clr = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] count;
    logic             dir;
    logic             step_pulse;
    logic             btn_level;
    logic             btn_press;
    logic             evt;

    typedef struct packed {
        logic             dir;
        logic [CNT_W-1:0] count;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             sb_e;
    logic [CNT_W-1:0] exp_count = '0;
    int               checks    = 0;
    int               errors    = 0;
    int               press_cnt = 0;
    logic             found;

    rotenc_ctrl #(.TICK_N(TICK_N), .DB_SAMPLES(DB_SAMPLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .clr(clr), .ack(ack), .count(count), .dir(dir), .step_pulse(step_pulse),
        .btn_level(btn_level), .btn_press(btn_press), .evt(evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic cw_detent();
        exp_count = exp_count + 8'd1;
        sb_q.push_back({1'b1, exp_count});
        drive_ab(2'b01); drive_ab(2'b00); drive_ab(2'b10); drive_ab(2'b11);
    endtask

    task automatic ccw_detent();
        exp_count = exp_count - 8'd1;
        sb_q.push_back({1'b0, exp_count});
        drive_ab(2'b10); drive_ab(2'b00); drive_ab(2'b01); drive_ab(2'b11);
    endtask

    // Scoreboard consumer: every step_pulse cycle must match a queued expectation
    always @(negedge clk) begin
        if (!reset) begin
            if (btn_press) press_cnt++;
            if (step_pulse) begin
                if (sb_q.size() == 0) begin
                    chk("step_unexpected", {31'b0, step_pulse}, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("step_count", {24'b0, count}, {24'b0, sb_e.count});
                    chk("step_dir", {31'b0, dir}, {31'b0, sb_e.dir});
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", {24'b0, count}, 32'd0);
        chk("rst_dir", {31'b0, dir}, 32'd0);
        chk("rst_step", {31'b0, step_pulse}, 32'd0);
        chk("rst_btn_level", {31'b0, btn_level}, 32'd0);
        chk("rst_btn_press", {31'b0, btn_press}, 32'd0);
        chk("rst_evt", {31'b0, evt}, 32'd0);
        chk("rst_state", {29'b0, dut.r_state}, {29'b0, REST});
        reset = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("idle_count", {24'b0, count}, 32'd0);

        // One clean CW detent
        cw_detent();
        chk("cw_count", {24'b0, count}, 32'h01);
        chk("cw_dir", {31'b0, dir}, 32'd1);
        chk("cw_evt", {31'b0, evt}, 32'd1);

        // Three CCW detents
        repeat (3) ccw_detent();
        chk("ccw_count", {24'b0, count}, 32'hFE);
        chk("ccw_dir", {31'b0, dir}, 32'd0);

        // Bounce on A: 8-cycle toggles phased so every tick sample reads high
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dut.w_tick) begin found = 1'b1; break; end
        end
        chk("tick_seen", {31'b0, found}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            enc_a = 1'b0; repeat (8) @(negedge clk);
            enc_a = 1'b1; repeat (8) @(negedge clk);
        end
        // 16-cycle toggles: tick samples alternate, so agreement never builds
        for (int i = 0; i < 6; i++) begin
            enc_a = 1'b0; repeat (16) @(negedge clk);
            enc_a = 1'b1; repeat (16) @(negedge clk);
        end
        repeat (HOLD) @(negedge clk);
        chk("bounce_count", {24'b0, count}, 32'hFE);
        chk("bounce_a_db", {31'b0, dut.w_a_db}, 32'd1);

        // Partial sequence returns to detent without a step
        drive_ab(2'b01); drive_ab(2'b00); drive_ab(2'b01); drive_ab(2'b11);
        chk("partial_count", {24'b0, count}, 32'hFE);
        chk("partial_state", {29'b0, dut.r_state}, {29'b0, REST});

        // Reset in the middle of a CW sequence
        drive_ab(2'b01); drive_ab(2'b00);
        chk("mid_state_cw2", {29'b0, dut.r_state}, {29'b0, CW2});
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_count", {24'b0, count}, 32'd0);
        chk("midrst_evt", {31'b0, evt}, 32'd0);
        chk("midrst_state", {29'b0, dut.r_state}, {29'b0, REST});
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        repeat (HOLD) @(negedge clk);
        drive_ab(2'b10); drive_ab(2'b11);
        chk("midrst_after_count", {24'b0, count}, 32'd0);
        chk("midrst_after_state", {29'b0, dut.r_state}, {29'b0, REST});

        // Wrap: 127 CW detents, then one more
        repeat (127) cw_detent();
        chk("wrap_7f", {24'b0, count}, 32'h7F);
        cw_detent();
        chk("wrap_80", {24'b0, count}, 32'h80);

        // clr in the same cycle as a CW step
        drive_ab(2'b01); drive_ab(2'b00); drive_ab(2'b10);
        exp_count = '0;
        sb_q.push_back({1'b1, exp_count});
        {enc_a, enc_b} = 2'b11;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.w_step_cw) begin found = 1'b1; break; end
        end
        chk("clr_step_seen", {31'b0, found}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_step_pulse", {31'b0, step_pulse}, 32'd1);
        chk("clr_count", {24'b0, count}, 32'd0);
        repeat (HOLD) @(negedge clk);
        chk("clr_evt", {31'b0, evt}, 32'd1);

        // Lone ack clears evt
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        chk("ack_clear_evt", {31'b0, evt}, 32'd0);

        // Button press with coincident ack
        enc_sw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (btn_press) begin found = 1'b1; break; end
        end
        chk("press_seen", {31'b0, found}, 32'd1);
        chk("press_level", {31'b0, btn_level}, 32'd1);
        chk("press_evt_before", {31'b0, evt}, 32'd0);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        chk("press_one_cycle", {31'b0, btn_press}, 32'd0);
        chk("press_evt_set_wins", {31'b0, evt}, 32'd1);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        chk("press_ack_clear", {31'b0, evt}, 32'd0);

        // Release: level falls, no second press
        enc_sw = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("release_level", {31'b0, btn_level}, 32'd0);
        chk("press_total", press_cnt, 32'd1);
        chk("release_evt", {31'b0, evt}, 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
